// File: rtl/bus_pkg.sv
// Shared definitions for the bus responder slice: FSM state encoding,
// slave-region geometry and the owner encoding.
// Optional feature macro used by this slice: BUS_ERR_EN.
package bus_pkg;

    // Responder FSM states (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Address-region geometry: top REGION_W address bits pick one of NUM_SLAVES
    localparam int REGION_W   = 2;
    localparam int NUM_SLAVES = 4;

    // Wait-state counter width; WAIT_CYCLES must fit in it (0..15)
    localparam int WAIT_CNT_W = 4;

    // Which master owns the transaction in flight
    typedef enum logic {
        OWNER_M1 = 1'b0,
        OWNER_M2 = 1'b1
    } owner_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational slave-region decoder. The top REGION_W address bits select
// one slave; the top region may be marked unmapped (BUS_ERR_EN builds), in
// which case no select is driven and the unmapped flag is raised instead.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  top_region_mapped,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  unmapped
);

    logic [REGION_W-1:0] region;
    logic                unused_addr_bits;

    assign region           = addr[ADDR_W-1 -: REGION_W];
    assign unused_addr_bits = ^addr[ADDR_W-REGION_W-1:0];

    // The last region is the only one that can be left unmapped
    assign unmapped = (region == REGION_W'(NUM_SLAVES - 1)) && !top_region_mapped;

    // One select line per slave, suppressed when the region is unmapped
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = (region == REGION_W'(gi)) && !unmapped;
        end
    endgenerate

endmodule

// File: rtl/bus_responder.sv
// Target-side bus responder: takes the transaction of the granted master,
// strobes the decoded slave, waits WAIT_CYCLES wait states and returns a
// one-cycle READY (plus read data) to the owning master.
// Optional feature macro: BUS_ERR_EN (top region unmapped, BUS_ERR reported).
module bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  GRANT0,
    input  logic                  GRANT1,
    input  logic                  MASTER1_READ,
    input  logic                  MASTER1_WRITE,
    input  logic                  MASTER2_READ,
    input  logic                  MASTER2_WRITE,
    input  logic [ADDR_W-1:0]     MASTER1_ADDR,
    input  logic [ADDR_W-1:0]     MASTER2_ADDR,
    input  logic [DATA_W-1:0]     MASTER1_WDATA,
    input  logic [DATA_W-1:0]     MASTER2_WDATA,
    output logic                  MASTER1_READY,
    output logic                  MASTER2_READY,
    output logic [DATA_W-1:0]     RDATA,
    output logic                  BUS_ERR,
    output logic [NUM_SLAVES-1:0] SLV_SEL,
    output logic [ADDR_W-1:0]     SLV_ADDR,
    output logic [DATA_W-1:0]     SLV_WDATA,
    output logic                  SLV_WE,
    output logic                  SLV_RE,
    input  logic [DATA_W-1:0]     SLV_RDATA
);

    // Counter reload value; WAIT_CYCLES above 15 does not fit and is illegal
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]            state_reg,    state_next;
    owner_t                owner_reg,    owner_next;
    logic                  write_reg,    write_next;
    logic [ADDR_W-1:0]     addr_reg,     addr_next;
    logic [DATA_W-1:0]     wdata_reg,    wdata_next;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [DATA_W-1:0]     rdata_reg,    rdata_next;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_unmapped;
    logic                  top_region_mapped;
    logic [DATA_W-1:0]     read_value;

`ifdef BUS_ERR_EN
    assign top_region_mapped = 1'b0;
    assign BUS_ERR           = (state_reg == ST_DONE) && dec_unmapped;
`else
    assign top_region_mapped = 1'b1;
    assign BUS_ERR           = 1'b0;
`endif

    bus_addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr              (addr_reg),
        .top_region_mapped (top_region_mapped),
        .sel               (dec_sel),
        .unmapped          (dec_unmapped)
    );

    // Unmapped reads return all ones instead of whatever the slave bus floats
    assign read_value = dec_unmapped ? {DATA_W{1'b1}} : SLV_RDATA;

    // Next-state logic: requests are only looked at in IDLE, master 1 first
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        write_next    = write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        wait_cnt_next = wait_cnt_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (GRANT0 && (MASTER1_READ || MASTER1_WRITE)) begin
                    owner_next = OWNER_M1;
                    write_next = MASTER1_WRITE;
                    addr_next  = MASTER1_ADDR;
                    wdata_next = MASTER1_WDATA;
                    state_next = ST_ACCESS;
                end else if (GRANT1 && (MASTER2_READ || MASTER2_WRITE)) begin
                    owner_next = OWNER_M2;
                    write_next = MASTER2_WRITE;
                    addr_next  = MASTER2_ADDR;
                    wdata_next = MASTER2_WDATA;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (WAIT_CYCLES == 0) begin
                    state_next = ST_DONE;
                end else begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WAIT_CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!write_reg) begin
                    rdata_next = read_value;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and latched-transaction registers; reset aborts any transaction
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWNER_M1;
            write_reg    <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wait_cnt_reg <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            write_reg    <= write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            wait_cnt_reg <= wait_cnt_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Select held from ACCESS through DONE so the slave drives data while sampled
    assign SLV_SEL   = (state_reg != ST_IDLE) ? dec_sel : '0;
    assign SLV_ADDR  = addr_reg;
    assign SLV_WDATA = wdata_reg;
    assign SLV_WE    = (state_reg == ST_ACCESS) && write_reg  && !dec_unmapped;
    assign SLV_RE    = (state_reg == ST_ACCESS) && !write_reg && !dec_unmapped;

    assign MASTER1_READY = (state_reg == ST_DONE) && (owner_reg == OWNER_M1);
    assign MASTER2_READY = (state_reg == ST_DONE) && (owner_reg == OWNER_M2);

    // Read data is passed through during DONE and held in rdata_reg afterwards
    assign RDATA = ((state_reg == ST_DONE) && !write_reg) ? read_value : rdata_reg;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed cases followed by random
// transactions compared against a transaction-level reference model.
// Honours BUS_ERR_EN when the design is built with it.
module tb_bus_responder;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int WC     = 2;
    // Edges from the start of the accepting IDLE cycle to the READY cycle
    localparam int LAT    = 2 + WC;
    // Index of the READY cycle counting the cycle after the accept edge as 0
    localparam int RDY_K  = LAT - 1;
`ifdef BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              GRANT0, GRANT1;
    logic              MASTER1_READ, MASTER1_WRITE, MASTER2_READ, MASTER2_WRITE;
    logic [ADDR_W-1:0] MASTER1_ADDR, MASTER2_ADDR;
    logic [DATA_W-1:0] MASTER1_WDATA, MASTER2_WDATA;
    logic              MASTER1_READY, MASTER2_READY;
    logic [DATA_W-1:0] RDATA;
    logic              BUS_ERR;
    logic [3:0]        SLV_SEL;
    logic [ADDR_W-1:0] SLV_ADDR;
    logic [DATA_W-1:0] SLV_WDATA;
    logic              SLV_WE, SLV_RE;
    logic [DATA_W-1:0] SLV_RDATA;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_rdata;

    always #5 clk = ~clk;

    bus_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .GRANT0        (GRANT0),
        .GRANT1        (GRANT1),
        .MASTER1_READ  (MASTER1_READ),
        .MASTER1_WRITE (MASTER1_WRITE),
        .MASTER2_READ  (MASTER2_READ),
        .MASTER2_WRITE (MASTER2_WRITE),
        .MASTER1_ADDR  (MASTER1_ADDR),
        .MASTER2_ADDR  (MASTER2_ADDR),
        .MASTER1_WDATA (MASTER1_WDATA),
        .MASTER2_WDATA (MASTER2_WDATA),
        .MASTER1_READY (MASTER1_READY),
        .MASTER2_READY (MASTER2_READY),
        .RDATA         (RDATA),
        .BUS_ERR       (BUS_ERR),
        .SLV_SEL       (SLV_SEL),
        .SLV_ADDR      (SLV_ADDR),
        .SLV_WDATA     (SLV_WDATA),
        .SLV_WE        (SLV_WE),
        .SLV_RE        (SLV_RE),
        .SLV_RDATA     (SLV_RDATA)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drop all requests and grants; scramble addresses/data so stale values show up
    task automatic clear_requests();
        GRANT0        = 1'b0;
        GRANT1        = 1'b0;
        MASTER1_READ  = 1'b0;
        MASTER1_WRITE = 1'b0;
        MASTER2_READ  = 1'b0;
        MASTER2_WRITE = 1'b0;
        MASTER1_ADDR  = 16'($urandom);
        MASTER2_ADDR  = 16'($urandom);
        MASTER1_WDATA = 8'($urandom);
        MASTER2_WDATA = 8'($urandom);
    endtask

    // One complete transaction for master m, checked against the model
    task automatic run_txn(input int m, input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] sr, input bit noise);
        int         region;
        bit         unm;
        bit         is_wr;
        logic [3:0] exp_sel;
        int         ready_k, own_cnt, other_cnt, we_cnt, re_cnt, strobe_k, err_cnt, sel_bad;
        logic [7:0] rdata_at_ready, wdata_at_we;
        logic       err_at_ready;
        logic [15:0] addr_seen;

        region  = int'(addr) / 16384;
        unm     = ERR_EN && (region == 3);
        is_wr   = wr;
        exp_sel = unm ? 4'b0000 : 4'(1 << region);
        if (!is_wr) model_rdata = unm ? 8'hFF : sr;

        ready_k = -1; own_cnt = 0; other_cnt = 0; we_cnt = 0; re_cnt = 0;
        strobe_k = -1; err_cnt = 0; sel_bad = 0;
        rdata_at_ready = 'x; wdata_at_we = 'x; err_at_ready = 1'bx; addr_seen = 'x;

        @(negedge clk);
        clear_requests();
        SLV_RDATA = sr;
        if (m == 1) begin
            GRANT0 = 1'b1; MASTER1_READ = rd; MASTER1_WRITE = wr;
            MASTER1_ADDR = addr; MASTER1_WDATA = wd;
            if (noise) begin
                GRANT1 = 1'($urandom_range(0, 1));
                MASTER2_READ = 1'b1;
            end
        end else begin
            GRANT1 = 1'b1; MASTER2_READ = rd; MASTER2_WRITE = wr;
            MASTER2_ADDR = addr; MASTER2_WDATA = wd;
            if (noise) begin
                if ($urandom_range(0, 1) == 1) GRANT0 = 1'b1;
                else MASTER1_WRITE = 1'b1;
            end
        end
        @(posedge clk);
        for (int k = 0; k < RDY_K + 4; k++) begin
            @(negedge clk);
            if (k == 0) addr_seen = SLV_ADDR;
            if (SLV_WE) begin we_cnt++; strobe_k = k; wdata_at_we = SLV_WDATA; end
            if (SLV_RE) begin re_cnt++; strobe_k = k; end
            if (BUS_ERR) err_cnt++;
            if ((m == 1) ? MASTER1_READY : MASTER2_READY) begin
                own_cnt++; ready_k = k; rdata_at_ready = RDATA; err_at_ready = BUS_ERR;
            end
            if ((m == 1) ? MASTER2_READY : MASTER1_READY) other_cnt++;
            if (SLV_SEL !== ((k <= RDY_K) ? exp_sel : 4'b0000)) sel_bad++;
            if (k == 0) clear_requests();
        end

        check("ready_cycle", ready_k, RDY_K);
        check("own_ready_pulses", own_cnt, 1);
        check("other_ready_pulses", other_cnt, 0);
        check("we_pulses", we_cnt, 32'(is_wr && !unm));
        check("re_pulses", re_cnt, 32'(!is_wr && !unm));
        if (we_cnt + re_cnt > 0) check("strobe_cycle", strobe_k, 0);
        check("sel_window", sel_bad, 0);
        check("slv_addr", 32'(addr_seen), 32'(addr));
        if (is_wr && !unm) check("slv_wdata", 32'(wdata_at_we), 32'(wd));
        check("rdata_at_ready", 32'(rdata_at_ready), 32'(model_rdata));
        check("bus_err_at_ready", 32'(err_at_ready), 32'(unm));
        check("bus_err_pulses", err_cnt, 32'(unm));
        check("rdata_held", 32'(RDATA), 32'(model_rdata));
        check("sel_idle", 32'(SLV_SEL), 0);
        $display("txn m%0d %s addr=%h wdata=%h slv_rdata=%h ready_k=%0d rdata=%h bus_err=%0b",
                 m, is_wr ? "WR" : "RD", addr, wd, sr, ready_k, rdata_at_ready, err_at_ready);
    endtask

    initial begin : stim
        int r1k, r2k, r1n, r2n, we_n, re_n, we_k, re_k, rdy_n;
        logic [3:0] sel_we, sel_re;
        logic [7:0] wd_seen, rd2;

        // Reset held with requests active
        rst = 1'b0;
        clear_requests();
        GRANT0 = 1'b1; MASTER1_WRITE = 1'b1; GRANT1 = 1'b1; MASTER2_READ = 1'b1;
        SLV_RDATA = 8'h99;
        model_rdata = 8'h00;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ctrl", 32'({MASTER1_READY, MASTER2_READY, BUS_ERR, SLV_SEL, SLV_WE, SLV_RE}), 0);
            check("reset_data", {RDATA, SLV_ADDR, SLV_WDATA}, 0);
        end
        rst = 1'b1;
        clear_requests();
        $display("txn reset released");

        // Master 1 write, master 2 read
        run_txn(1, 1'b0, 1'b1, 16'h4010, 8'hA5, 8'h00, 1'b0);
        run_txn(2, 1'b1, 1'b0, 16'h8003, 8'h11, 8'h3C, 1'b0);

        // Both grants, master 1 READ+WRITE, master 2 waiting for the IDLE gap
        @(negedge clk);
        clear_requests();
        GRANT0 = 1'b1; GRANT1 = 1'b1;
        MASTER1_READ = 1'b1; MASTER1_WRITE = 1'b1;
        MASTER1_ADDR = 16'h1234; MASTER1_WDATA = 8'h5A;
        MASTER2_READ = 1'b1; MASTER2_ADDR = 16'h8001;
        SLV_RDATA = 8'h77;
        r1k = -1; r2k = -1; r1n = 0; r2n = 0; we_n = 0; re_n = 0; we_k = -1; re_k = -1;
        sel_we = 'x; sel_re = 'x; wd_seen = 'x; rd2 = 'x;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (MASTER1_READY) begin r1n++; r1k = k; end
            if (MASTER2_READY) begin r2n++; r2k = k; rd2 = RDATA; end
            if (SLV_WE) begin we_n++; we_k = k; wd_seen = SLV_WDATA; sel_we = SLV_SEL; end
            if (SLV_RE) begin re_n++; re_k = k; sel_re = SLV_SEL; end
            if (k == 0) begin MASTER1_READ = 1'b0; MASTER1_WRITE = 1'b0; GRANT0 = 1'b0; end
            if (k == RDY_K + 2) clear_requests();
        end
        model_rdata = 8'h77;
        check("arb_m1_ready_k", r1k, RDY_K);
        check("arb_m2_ready_k", r2k, RDY_K + 1 + LAT);
        check("arb_ready_spacing_ge5", 32'((r2k - r1k) >= 5), 1);
        check("arb_m1_pulses", r1n, 1);
        check("arb_m2_pulses", r2n, 1);
        check("arb_we_pulses", we_n, 1);
        check("arb_we_cycle", we_k, 0);
        check("arb_we_sel", 32'(sel_we), 32'(4'b0001));
        check("arb_wdata", 32'(wd_seen), 32'(8'h5A));
        check("arb_re_pulses", re_n, 1);
        check("arb_re_cycle", re_k, RDY_K + 2);
        check("arb_re_sel", 32'(sel_re), 32'(4'b0100));
        check("arb_m2_rdata", 32'(rd2), 32'(model_rdata));
        $display("txn both-grants m1_ready_k=%0d m2_ready_k=%0d m2_rdata=%h", r1k, r2k, rd2);

        // Reset during WAIT aborts the transaction
        @(negedge clk);
        clear_requests();
        GRANT0 = 1'b1; MASTER1_WRITE = 1'b1; MASTER1_ADDR = 16'h2222; MASTER1_WDATA = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        clear_requests();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_rdata = 8'h00;
        check("midreset_ctrl", 32'({MASTER1_READY, MASTER2_READY, BUS_ERR, SLV_SEL, SLV_WE, SLV_RE}), 0);
        check("midreset_data", {RDATA, SLV_ADDR, SLV_WDATA}, 0);
        rst = 1'b1;
        rdy_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (MASTER1_READY || MASTER2_READY) rdy_n++;
        end
        check("midreset_no_ready", rdy_n, 0);
        $display("txn reset during WAIT, ready pulses afterwards=%0d", rdy_n);
        run_txn(1, 1'b1, 1'b0, 16'h0042, 8'h00, 8'hC3, 1'b0);

        // Top region read (unmapped only when BUS_ERR_EN is defined)
        run_txn(1, 1'b1, 1'b0, 16'hC000, 8'h00, 8'h42, 1'b0);
        run_txn(2, 1'b0, 1'b1, 16'hC0F0, 8'h6B, 8'h24, 1'b0);

        // Random transactions against the model
        for (int t = 0; t < 20; t++) begin
            int  m, kind;
            m    = int'($urandom_range(1, 2));
            kind = int'($urandom_range(0, 2));
            run_txn(m, kind != 1, kind != 0, 16'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target-side counterpart of the internal-bus arbiter. It accepts the transaction of whichever master currently holds GRANT0/GRANT1 and latches that master's address, data and direction.
- It decodes the address to one of four slave selects, strobes the slave, and waits a fixed number of wait states.
- It then returns read data and a one-cycle READY pulse to the owning master.
- Sits between the arbiter/master ports and the memory/peripheral slaves.

Parameters:
- ADDR_W, 16, address width; the top 2 bits select the slave region.
- DATA_W, 8, data width.
- WAIT_CYCLES, 2, wait states between the slave strobe and the response (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- GRANT0  in  1  arbiter grant to master 1 (higher priority)
- GRANT1  in  1  arbiter grant to master 2
- MASTER1_READ, MASTER1_WRITE  in  1 each  master 1 request
- MASTER2_READ, MASTER2_WRITE  in  1 each  master 2 request
- MASTER1_ADDR, MASTER2_ADDR  in  ADDR_W  request addresses
- MASTER1_WDATA, MASTER2_WDATA  in  DATA_W  write data
- MASTER1_READY, MASTER2_READY  out  1  one-cycle completion pulse to the owning master
- RDATA  out  DATA_W  read data; valid while READY is high, held until the next read completes
- BUS_ERR  out  1  error pulse, coincident with READY (optional feature only)
- SLV_SEL  out  4  one-hot slave select
- SLV_ADDR  out  ADDR_W  latched address
- SLV_WDATA  out  DATA_W  latched write data
- SLV_WE, SLV_RE  out  1  one-cycle slave strobes
- SLV_RDATA  in  DATA_W  slave read data; sampled in DONE

Behaviour:
- Reset: rst low at a clk edge forces IDLE. All outputs go to 0, including RDATA and the latched address/data. Reset mid-transaction aborts it; no READY is issued.
- FSM states and transitions:
  - IDLE: if GRANT0 & (MASTER1_READ|MASTER1_WRITE), latch master 1's address, data and direction, set owner=0, go to ACCESS. Else if GRANT1 & (MASTER2_READ|MASTER2_WRITE), do the same for master 2 with owner=1. Else stay in IDLE.
  - ACCESS (1 cycle): SLV_SEL = onehot(SLV_ADDR[ADDR_W-1:ADDR_W-2]). SLV_WE or SLV_RE is high for this cycle only. Next state is WAIT, or DONE if WAIT_CYCLES=0.
  - WAIT: a counter loaded with WAIT_CYCLES-1 decrements each cycle; at 0, go to DONE. SLV_SEL stays asserted; strobes stay low.
  - DONE (1 cycle): on a read, RDATA <= SLV_RDATA. The owning master's READY is high for exactly one cycle. Return to IDLE. SLV_SEL is deasserted in IDLE.
- Latency: request accepted at edge N; READY is high during the cycle after edge N+2+WAIT_CYCLES. Default is 4 cycles from IDLE accept to READY.
- Both grants high (illegal): GRANT0/master 1 wins.
- READ and WRITE both high: treated as a write.
- Request or grant dropped mid-transaction: the transaction still completes and READY still pulses. Inputs are sampled only in IDLE.
- Back-to-back: a request still high in the IDLE cycle after DONE starts a new transaction. Minimum spacing is therefore READY + 1 cycle.
- Only one transaction is outstanding; there is no buffering.
- WAIT_CYCLES wraps nowhere: the counter is 4 bits and parameter values above 15 are illegal.

Optional Feature:
- Macro: BUS_ERR_EN.
- Defined:
  - Region 3 (top bits 2'b11) is unmapped.
  - No SLV_SEL bit, SLV_WE or SLV_RE is asserted for it.
  - Timing through WAIT is unchanged.
  - In DONE, READY and BUS_ERR pulse together, and RDATA <= all ones on a read.
- Undefined:
  - Region 3 selects SLV_SEL[3] normally.
  - The BUS_ERR port exists and is tied 0.

Decomposition:
- Shared package bus_pkg holds:
  - the state encoding (IDLE, ACCESS, WAIT, DONE, 2-bit);
  - region constants REGION_W=2 and NUM_SLAVES=4;
  - the owner encoding.
- One natural sub-module: bus_addr_decode. It is combinational; inputs are the address and the BUS_ERR_EN-dependent valid flag; outputs are one-hot SLV_SEL and an unmapped flag.

Test Plan:
- Reset: hold rst=0 for 3 cycles with requests active -> all outputs 0, state IDLE, no READY.
- Master 1 write: GRANT0=1, MASTER1_WRITE=1, ADDR=16'h4010, WDATA=8'hA5 -> SLV_SEL=4'b0010, SLV_WE pulses 1 cycle with SLV_WDATA=A5, MASTER1_READY pulses 4 cycles after accept, MASTER2_READY stays 0.
- Master 2 read: GRANT1=1, MASTER2_READ=1, ADDR=16'h8003, SLV_RDATA=8'h3C -> SLV_SEL=4'b0100, SLV_RE 1 cycle, RDATA=3C with MASTER2_READY; RDATA still 3C afterwards.
- Both grants plus simultaneous requests, and master 1 READ+WRITE -> master 1 served as a write; master 2 served next after the IDLE gap; READY spacing at least 5 cycles.
- Reset asserted during WAIT -> IDLE next edge, no READY; a fresh request afterwards completes normally.
- BUS_ERR_EN, read of ADDR=16'hC000 -> no SLV_SEL or strobes, READY and BUS_ERR pulse together, RDATA=8'hFF. Without the macro -> SLV_SEL=4'b1000, BUS_ERR stays 0.
